// File: rtl/seq_alu_exec.sv
// seq_alu_exec: EX-stage execution unit driven by the {funct7[5],funct3} ALU field.
// Single-cycle logic/arithmetic ops; shifts iterate one bit per cycle.
// Valid/ready handshakes on both sides let the pipeline stall around long shifts.
module seq_alu_exec #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      field,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [SHW-1:0]  count;
    logic            shift_right;
    logic            shift_arith;

    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic [XLEN-1:0] alu_value;
    logic [XLEN-1:0] shift_step;

    // funct3 001 (SLL) and 101 (SRL/SRA) are the only iterative ops
    assign shamt    = op_b[SHW-1:0];
    assign is_shift = (field[1:0] == 2'b01);
    assign in_ready = (state == IDLE);
    assign zero     = (result == '0);

    // Single-cycle result for the op currently presented at the input
    always_comb begin
        alu_value = '0;
        case (field[2:0])
            3'b000:  alu_value = field[3] ? (op_a - op_b) : (op_a + op_b);
            3'b001:  alu_value = op_a;
            3'b010:  alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011:  alu_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100:  alu_value = op_a ^ op_b;
            3'b101:  alu_value = op_a;
            3'b110:  alu_value = op_a | op_b;
            default: alu_value = op_a & op_b;
        endcase
    end

    // One-bit shift of the working value in the direction latched at accept time
    always_comb begin
        shift_step = result;
        if (!shift_right) begin
            shift_step = {result[XLEN-2:0], 1'b0};
        end else if (shift_arith) begin
            shift_step = {result[XLEN-1], result[XLEN-1:1]};
        end else begin
            shift_step = {1'b0, result[XLEN-1:1]};
        end
    end

    // Control FSM with registered result, count and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            count       <= '0;
            shift_right <= 1'b0;
            shift_arith <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_right <= field[2];
                        shift_arith <= field[3];
                        if (is_shift && (shamt != '0)) begin
                            result <= op_a;
                            count  <= shamt;
                            state  <= SHIFT;
                        end else begin
                            result    <= alu_value;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    result <= shift_step;
                    count  <= count - 1'b1;
                    if (count == SHW'(1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_exec.sv
// tb_seq_alu_exec: directed and randomized checks of seq_alu_exec against
// an arithmetic reference model of the ALU field decode and shift latency.
module tb_seq_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  field;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int total;
    int bad;
    logic [31:0] exp_res;
    int          exp_lat;

    seq_alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .field     (field),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the instruction semantics
    function automatic logic [31:0] ref_result(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (f[2:0])
            3'd0:    return f[3] ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f[3] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Extra cycles beyond the accept cycle: shift amount for shifts, none otherwise
    function automatic int ref_latency(input logic [3:0] f, input logic [31:0] b);
        if (f[2:0] == 3'd1 || f[2:0] == 3'd5) return int'(b[4:0]);
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        field    = f;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        exp_res  = ref_result(f, a, b);
        exp_lat  = ref_latency(f, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic checkOutput(input string tag, input int stall);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < 64) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
        chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_result"}, result, exp_res);
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_handoff_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_handoff_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Directed steps followed by a randomized sweep
    initial begin
        logic [3:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rstall;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        field     = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        out_ready = 1'b1;
        exp_res   = 32'd0;
        exp_lat   = 0;

        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] directed operations");
        applyStimulus(4'b0000, 32'd5, 32'd7);                 checkOutput("add_5_7", 0);
        applyStimulus(4'b1000, 32'd3, 32'd5);                 checkOutput("sub_3_5", 0);
        applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'd1);         checkOutput("add_wrap", 0);
        applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1);         checkOutput("slt", 0);
        applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'd1);         checkOutput("sltu", 0);
        applyStimulus(4'b1101, 32'h8000_0000, 32'd4);         checkOutput("sra_4", 0);
        applyStimulus(4'b0101, 32'h8000_0000, 32'd4);         checkOutput("srl_4", 0);
        applyStimulus(4'b0001, 32'h0000_0001, 32'd0);         checkOutput("sll_0", 0);
        applyStimulus(4'b1001, 32'h0000_0003, 32'd5);         checkOutput("sll_alias", 0);
        applyStimulus(4'b1110, 32'h0F0F_0000, 32'h0000_F0F0); checkOutput("or_alias", 0);
        applyStimulus(4'b0101, 32'hDEAD_BEEF, 32'd31);        checkOutput("srl_31", 0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(4'b0100, 32'hA5A5_A5A5, 32'h5A5A_5A5A); checkOutput("xor_stall", 3);

        $display("[TB] reset during shift");
        applyStimulus(4'b0001, 32'h0000_0001, 32'd31);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("midshift_valid_low", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_still_idle", {31'd0, out_valid}, 32'd0);
        applyStimulus(4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0); checkOutput("and_after_rst", 0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            rf     = 4'($urandom);
            ra     = $urandom;
            rb     = $urandom;
            if (i % 10 == 0) rb = ra;
            rstall = $urandom_range(0, 2);
            out_ready = (rstall == 0);
            applyStimulus(rf, ra, rb);
            checkOutput($sformatf("rand%0d_f%0h", i, rf), rstall);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
